// File: rtl/weight_acquire_pkg.sv
// Shared types and defaults for the load-cell weight acquisition path.
package weight_acquire_pkg;

    localparam int ADC_W          = 16;
    localparam int AVG_LOG2_DEF   = 2;
    localparam int STABLE_CNT_DEF = 8;
    localparam int STABLE_TOL_DEF = 2;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_TARE = 2'd2
    } state_t;

    function automatic logic [ADC_W-1:0] abs_diff(input logic [ADC_W-1:0] a,
                                                  input logic [ADC_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/weight_avg.sv
// Moving-average window over the last 2^AVG_LOG2 accepted samples.
module weight_avg
    import weight_acquire_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [ADC_W-1:0] i_data,
    output logic [ADC_W-1:0] o_avg,
    output logic             o_fill_done
);
    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = ADC_W + AVG_LOG2;

    logic [N-1:0][ADC_W-1:0] r_win;
    logic [SUM_W-1:0]        r_sum;
    logic [AVG_LOG2:0]       r_cnt;
    logic                    r_full;

    // Empty slots hold zero, so the running sum stays exact while filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win  <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_valid) begin
            r_win[0] <= i_data;
            for (int i = 1; i < N; i++) r_win[i] <= r_win[i-1];
            r_sum <= r_sum + SUM_W'(i_data) - SUM_W'(r_win[N-1]);
            if (!r_full) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == (AVG_LOG2+1)'(N-1)) r_full <= 1'b1;
            end
        end
    end

    assign o_avg       = r_sum[SUM_W-1:AVG_LOG2];
    assign o_fill_done = i_valid && !r_full && (r_cnt == (AVG_LOG2+1)'(N-1));

endmodule

// File: rtl/weight_acquire.sv
// Averaged, tared net weight with a settle detector, one cycle behind each sample.
module weight_acquire
    import weight_acquire_pkg::*;
#(
    parameter int AVG_LOG2   = AVG_LOG2_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int STABLE_TOL = STABLE_TOL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             tare_req,
    output logic [ADC_W-1:0] weight_kg,
    output logic             weight_valid,
    output logic             weight_stable,
    output logic             tare_busy
);
    localparam int CW = $clog2(STABLE_CNT + 1);

    state_t           r_state;
    logic             r_pend;
    logic [ADC_W-1:0] r_offset;
    logic [ADC_W-1:0] r_prev;
    logic             r_have_prev;
    logic [CW-1:0]    r_cnt;
    logic [ADC_W-1:0] r_kg;
    logic             r_valid;
    logic             r_stable;
    logic             r_busy;

    logic [ADC_W-1:0] w_avg;
    logic             w_fill_done;
    logic [ADC_W-1:0] w_net;
    logic [CW-1:0]    w_cnt_nxt;

    weight_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (adc_valid),
        .i_data      (adc_data),
        .o_avg       (w_avg),
        .o_fill_done (w_fill_done)
    );

    always_comb begin
        w_net     = (w_avg >= r_offset) ? (w_avg - r_offset) : '0;
        w_cnt_nxt = '0;
        if (r_have_prev && abs_diff(w_net, r_prev) <= ADC_W'(STABLE_TOL))
            w_cnt_nxt = (r_cnt == CW'(STABLE_CNT)) ? r_cnt : r_cnt + 1'b1;
    end

    // r_pend marks that the average was updated by a sample on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_pend      <= 1'b0;
            r_offset    <= '0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_cnt       <= '0;
            r_kg        <= '0;
            r_valid     <= 1'b0;
            r_stable    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_pend) begin
                r_valid     <= 1'b1;
                r_have_prev <= 1'b1;
                if (r_state == ST_TARE) begin
                    r_offset <= w_avg;
                    r_kg     <= '0;
                    r_prev   <= '0;
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else begin
                    r_kg     <= w_net;
                    r_prev   <= w_net;
                    r_cnt    <= w_cnt_nxt;
                    r_stable <= (w_cnt_nxt == CW'(STABLE_CNT));
                end
            end
            case (r_state)
                ST_FILL: begin
                    r_pend <= w_fill_done;
                    if (tare_req) r_busy <= 1'b1;
                    if (w_fill_done) r_state <= (r_busy || tare_req) ? ST_TARE : ST_RUN;
                end
                ST_RUN: begin
                    r_pend <= adc_valid;
                    if (tare_req) begin
                        r_state <= ST_TARE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_TARE: begin
                    r_pend <= adc_valid;
                    if (r_pend) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign weight_kg     = r_kg;
    assign weight_valid  = r_valid;
    assign weight_stable = r_stable;
    assign tare_busy     = r_busy;

endmodule

// File: doc/weight_acquire.md
WEIGHT_ACQUIRE -- requirements
Module: weight_acquire

Interface
REQ-001 The module SHALL have parameter AVG_LOG2, default 2, giving log2 of the moving-average window (window = 4 samples).
REQ-002 The module SHALL have parameter STABLE_CNT, default 8, the number of consecutive in-tolerance outputs that declares the weight stable.
REQ-003 The module SHALL have parameter STABLE_TOL, default 2, the maximum absolute difference between consecutive outputs that counts as in-tolerance.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The module SHALL have port adc_data, input, 16 bits, the raw unsigned load-cell sample in kg units.
REQ-007 The module SHALL have port adc_valid, input, 1 bit; adc_data is sampled on every edge where adc_valid is high.
REQ-008 The module SHALL have port tare_req, input, 1 bit, a single-cycle tare request pulse.
REQ-009 The module SHALL have port weight_kg, output, 16 bits, the net weight consumed by the downstream price stage (preco).
REQ-010 The module SHALL have port weight_valid, output, 1 bit, a one-cycle pulse marking a new weight_kg.
REQ-011 The module SHALL have port weight_stable, output, 1 bit, a level signal asserted while the reading is settled.
REQ-012 The module SHALL have port tare_busy, output, 1 bit, high while a tare request is pending.

Function
REQ-013 The module SHALL keep a window of the last 2^AVG_LOG2 accepted samples and a sum of width 16+AVG_LOG2 bits, with no overflow.
REQ-014 The average SHALL be sum >> AVG_LOG2, truncated.
REQ-015 Net weight SHALL be average minus tare_offset, saturating at 0 when average < tare_offset.
REQ-016 The FSM SHALL have three states: FILL (window not yet full), RUN, and TARE.
REQ-017 After reset the FSM SHALL be in FILL; it SHALL move to RUN on the edge that accepts the 2^AVG_LOG2-th sample.
REQ-018 No weight_valid SHALL be produced in FILL.
REQ-019 In RUN and TARE, each sample accepted at edge k SHALL update weight_kg and pulse weight_valid at edge k+1 (fixed 1-cycle latency); weight_kg SHALL hold its value between pulses.
REQ-020 A tare_req in RUN SHALL move the FSM to TARE and set tare_busy.
REQ-021 In TARE, the next computed average SHALL be loaded into tare_offset; that sample's output SHALL be weight_kg = 0 with weight_valid pulsed; the FSM SHALL then return to RUN and clear tare_busy.
REQ-022 A tare_req on the same edge as adc_valid in RUN SHALL apply the tare to the average of that sample.
REQ-023 A tare_req in FILL SHALL be latched (tare_busy high) and executed on the first average once the window is full.
REQ-024 A tare_req in TARE SHALL be ignored.
REQ-025 Stability: on each weight_valid, if |weight_kg_new - weight_kg_prev| <= STABLE_TOL, the stability counter SHALL increment, saturating at STABLE_CNT; otherwise it SHALL clear to 0.
REQ-026 The first output after FILL SHALL only load the previous-weight reference and SHALL leave the counter at 0.
REQ-027 weight_stable SHALL be high exactly while counter == STABLE_CNT, and SHALL be cleared on any tare event.

Reset
REQ-028 When rst is high at an edge, the following SHALL be cleared to 0: window, sum, tare_offset, stability counter, weight_kg, weight_valid, weight_stable and tare_busy; the FSM SHALL be set to FILL.
REQ-029 Reset mid-operation SHALL discard any pending tare and any partially filled window.
REQ-030 adc_valid SHALL be ignored during reset.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (FILL, RUN, TARE) and the default parameter constants.
REQ-032 The window, sum and average SHALL be implemented as sub-module weight_avg; the FSM, tare logic and stability logic SHALL live in weight_acquire.

Verification
REQ-033 The bench SHALL check: constant 400 on every cycle -> no valid for samples 1–3; weight_kg=400 with valid one cycle after sample 4; weight_stable rises with the 9th valid.
REQ-034 The bench SHALL check: constant 100, tare_req in RUN -> next output 0, tare_busy high for that interval; then a step to 500 -> after 4 samples weight_kg=400 steady.
REQ-035 The bench SHALL check: tare at 100, then input 40 -> weight_kg saturates at 0 with no wrap to 65476.
REQ-036 The bench SHALL check: stable at 400, then one sample of 440 -> average 410, weight_stable drops on that valid, and the counter restarts.
REQ-037 The bench SHALL check: tare_req during FILL at sample 2 with constant 250 -> tare_busy held; first output is 0 and later outputs are 0.
REQ-038 The bench SHALL check: rst asserted after sample 2, then samples resume -> the FILL restarts, requiring 4 new samples before valid, and tare_offset = 0.
